ptw_miss_arbiter: RTL and testbench

Arbitrates ITLB and DTLB miss requests onto the single shared-TLB lookup and page-table-walker (Sv32) path. It sequences each miss: shared-TLB lookup, hit/miss check, PTW walk tracking and completion. It returns a done/error pulse to the originating TLB and keeps per-source walk counters. It sits between the ITLB/DTLB miss logic and the shared TLB + PTW.

---
 rtl/ptw_miss_arbiter.sv | 154 +++++++++++++++
 tb/tb_ptw_miss_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_miss_arbiter.sv
// ptw_miss_arbiter: round-robin ITLB/DTLB miss arbiter that sequences the
// shared-TLB lookup and Sv32 PTW walk, with per-source walk counters.
module ptw_miss_arbiter #(
    parameter int VLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             itlb_miss_i,
    input  logic [VLEN-1:0]  itlb_vaddr_i,
    output logic             itlb_grant_o,
    output logic             itlb_done_o,
    input  logic             dtlb_miss_i,
    input  logic [VLEN-1:0]  dtlb_vaddr_i,
    input  logic             dtlb_is_store_i,
    output logic             dtlb_grant_o,
    output logic             dtlb_done_o,
    output logic             error_o,
    output logic             shared_tlb_access_o,
    output logic [VLEN-1:0]  shared_tlb_vaddr_o,
    output logic             itlb_req_o,
    output logic             lsu_is_store_o,
    input  logic             shared_tlb_hit_i,
    input  logic             ptw_active_i,
    input  logic             ptw_error_i,
    input  logic             ptw_access_exception_i,
    output logic [CNT_W-1:0] itlb_walks_o,
    output logic [CNT_W-1:0] dtlb_walks_o
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, WALK, RESP, FLUSH_WAIT
    } state_t;

    state_t          state;
    logic            prio_itlb;
    logic            src_itlb;
    logic            seen;
    logic            err;
    logic [1:0]      wdog;
    logic [VLEN-1:0] vaddr;
    logic            grant_ok;
    logic            pick_itlb;
    logic            fault;
    logic            timeout;

    assign grant_ok  = (state == IDLE) && !flush_i;
    assign pick_itlb = itlb_miss_i && (!dtlb_miss_i || prio_itlb);

    assign itlb_grant_o = grant_ok && pick_itlb;
    assign dtlb_grant_o = grant_ok && dtlb_miss_i && !pick_itlb;

    // Errors raised on the same cycle the walk ends must still count.
    assign fault   = err || ptw_error_i || ptw_access_exception_i;
    assign timeout = !seen && !ptw_active_i && (wdog == 2'd1);

    assign shared_tlb_vaddr_o = vaddr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state               <= IDLE;
            prio_itlb           <= 1'b0;
            src_itlb            <= 1'b0;
            seen                <= 1'b0;
            err                 <= 1'b0;
            wdog                <= 2'd0;
            vaddr               <= '0;
            shared_tlb_access_o <= 1'b0;
            itlb_req_o          <= 1'b0;
            lsu_is_store_o      <= 1'b0;
            itlb_done_o         <= 1'b0;
            dtlb_done_o         <= 1'b0;
            error_o             <= 1'b0;
            itlb_walks_o        <= '0;
            dtlb_walks_o        <= '0;
        end else begin
            shared_tlb_access_o <= 1'b0;
            itlb_req_o          <= 1'b0;
            lsu_is_store_o      <= 1'b0;
            itlb_done_o         <= 1'b0;
            dtlb_done_o         <= 1'b0;
            error_o             <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (itlb_grant_o || dtlb_grant_o) begin
                        vaddr <= itlb_grant_o ? itlb_vaddr_i
                                              : dtlb_vaddr_i;
                        src_itlb  <= itlb_grant_o;
                        prio_itlb <= dtlb_grant_o;
                        shared_tlb_access_o <= 1'b1;
                        itlb_req_o          <= itlb_grant_o;
                        lsu_is_store_o      <= dtlb_grant_o
                                               && dtlb_is_store_i;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= flush_i ? IDLE : CHECK;
                end
                CHECK: begin
                    if (shared_tlb_hit_i) begin
                        if (flush_i) begin
                            state <= IDLE;
                        end else begin
                            state       <= RESP;
                            itlb_done_o <= src_itlb;
                            dtlb_done_o <= !src_itlb;
                        end
                    end else begin
                        // The PTW starts on a miss, so count it even if flushed.
                        if (src_itlb && itlb_walks_o != '1)
                            itlb_walks_o <= itlb_walks_o + 1'b1;
                        if (!src_itlb && dtlb_walks_o != '1)
                            dtlb_walks_o <= dtlb_walks_o + 1'b1;
                        seen  <= 1'b0;
                        err   <= 1'b0;
                        wdog  <= 2'd3;
                        state <= flush_i ? FLUSH_WAIT : WALK;
                    end
                end
                WALK: begin
                    if (flush_i) begin
                        state <= FLUSH_WAIT;
                    end else if (seen && !ptw_active_i) begin
                        state       <= RESP;
                        itlb_done_o <= src_itlb;
                        dtlb_done_o <= !src_itlb;
                        error_o     <= fault;
                    end else if (timeout) begin
                        state       <= RESP;
                        itlb_done_o <= src_itlb;
                        dtlb_done_o <= !src_itlb;
                        error_o     <= 1'b1;
                    end else begin
                        err <= fault;
                        if (ptw_active_i) seen <= 1'b1;
                        if (!seen) wdog <= wdog - 2'd1;
                    end
                end
                FLUSH_WAIT: begin
                    if (!ptw_active_i) state <= IDLE;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_miss_arbiter.sv
// Directed bench for ptw_miss_arbiter: a per-scenario transaction model
// predicts every output cycle by cycle; literal pins anchor the model.
module tb_ptw_miss_arbiter;

    localparam int L = 80;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        itlb_miss_i;
    logic [31:0] itlb_vaddr_i;
    logic        dtlb_miss_i;
    logic [31:0] dtlb_vaddr_i;
    logic        dtlb_is_store_i;
    logic        shared_tlb_hit_i;
    logic        ptw_active_i;
    logic        ptw_error_i;
    logic        ptw_access_exception_i;

    logic        itlb_grant, itlb_done, dtlb_grant, dtlb_done;
    logic        error, access, itlb_req, lsu_store;
    logic [31:0] svaddr;
    logic [15:0] iwalks, dwalks;

    logic        s_igr, s_idone, s_dgr, s_ddone;
    logic        s_err, s_acc, s_ireq, s_st;
    logic [31:0] s_va;
    logic [2:0]  s_iw, s_dw;

    always #5 clk = ~clk;

    ptw_miss_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .itlb_miss_i(itlb_miss_i), .itlb_vaddr_i(itlb_vaddr_i),
        .itlb_grant_o(itlb_grant), .itlb_done_o(itlb_done),
        .dtlb_miss_i(dtlb_miss_i), .dtlb_vaddr_i(dtlb_vaddr_i),
        .dtlb_is_store_i(dtlb_is_store_i),
        .dtlb_grant_o(dtlb_grant), .dtlb_done_o(dtlb_done),
        .error_o(error), .shared_tlb_access_o(access),
        .shared_tlb_vaddr_o(svaddr), .itlb_req_o(itlb_req),
        .lsu_is_store_o(lsu_store),
        .shared_tlb_hit_i(shared_tlb_hit_i),
        .ptw_active_i(ptw_active_i), .ptw_error_i(ptw_error_i),
        .ptw_access_exception_i(ptw_access_exception_i),
        .itlb_walks_o(iwalks), .dtlb_walks_o(dwalks)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    ptw_miss_arbiter #(.CNT_W(3)) u_sat (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .itlb_miss_i(itlb_miss_i), .itlb_vaddr_i(itlb_vaddr_i),
        .itlb_grant_o(s_igr), .itlb_done_o(s_idone),
        .dtlb_miss_i(dtlb_miss_i), .dtlb_vaddr_i(dtlb_vaddr_i),
        .dtlb_is_store_i(dtlb_is_store_i),
        .dtlb_grant_o(s_dgr), .dtlb_done_o(s_ddone),
        .error_o(s_err), .shared_tlb_access_o(s_acc),
        .shared_tlb_vaddr_o(s_va), .itlb_req_o(s_ireq),
        .lsu_is_store_o(s_st),
        .shared_tlb_hit_i(shared_tlb_hit_i),
        .ptw_active_i(ptw_active_i), .ptw_error_i(ptw_error_i),
        .ptw_access_exception_i(ptw_access_exception_i),
        .itlb_walks_o(s_iw), .dtlb_walks_o(s_dw)
    );

    int total = 0;
    int passed = 0;

    function automatic void chk(string nm, int c,
                                logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s cycle %0d: got %h expected %h",
                     nm, c, got, exp);
        else
            passed++;
    endfunction

    // Scenario description
    int          n, ia, ni, da, nd;
    bit          dstore;
    logic [31:0] ibase, dbase;
    bit          hit[L], act[L], perr[L], pexc[L], fl[L];

    // Model predictions
    bit          e_imiss[L], e_dmiss[L];
    logic [31:0] e_iaddr[L], e_daddr[L], e_va[L];
    bit          e_igr[L], e_dgr[L], e_acc[L], e_ireq[L], e_st[L];
    bit          e_idone[L], e_ddone[L], e_err[L];
    int          e_icnt[L], e_dcnt[L];

    function automatic void clear_scn();
        n = 0; ia = 0; ni = 0; da = 0; nd = 0;
        dstore = 0; ibase = '0; dbase = '0;
        for (int c = 0; c < L; c++) begin
            hit[c] = 0; act[c] = 0; perr[c] = 0;
            pexc[c] = 0; fl[c] = 0;
        end
    endfunction

    function automatic void mark_done(int c, bit src_i, bit e);
        if (c < n) begin
            if (src_i) e_idone[c] = 1;
            else e_ddone[c] = 1;
            e_err[c] = e;
        end
    endfunction

    // Walk through the request stream as whole transactions.
    function automatic void build();
        bit          inc_i[L], inc_d[L], va_set[L];
        logic [31:0] va_val[L];
        int          is, ds, t, g, a, k, w, c, fin, fw, f;
        bit          prio_i, ir, dr, pi, st, seen, e, fe, flw, flc;
        logic [31:0] addr, cur;
        int          ic, dc;
        for (int j = 0; j < L; j++) begin
            e_igr[j] = 0; e_dgr[j] = 0; e_acc[j] = 0; e_ireq[j] = 0;
            e_st[j] = 0; e_idone[j] = 0; e_ddone[j] = 0; e_err[j] = 0;
            inc_i[j] = 0; inc_d[j] = 0; va_set[j] = 0; va_val[j] = '0;
        end
        is = 0; ds = 0; prio_i = 0; t = 0;
        while (t < n) begin
            g = -1;
            for (int j = t; j < n; j++)
                if (!fl[j] && ((j >= ia && is < ni) ||
                               (j >= da && ds < nd))) begin
                    g = j;
                    break;
                end
            if (g < 0) break;
            ir = (g >= ia) && (is < ni);
            dr = (g >= da) && (ds < nd);
            pi = ir && (!dr || prio_i);
            prio_i = !pi;
            if (pi) begin
                e_igr[g] = 1;
                addr = ibase + 32'(is) * 32'h1000;
                is++;
                st = 0;
            end else begin
                e_dgr[g] = 1;
                addr = dbase + 32'(ds) * 32'h1000;
                ds++;
                st = dstore;
            end
            a = g + 1;
            if (a >= n) break;
            e_acc[a] = 1; e_ireq[a] = pi; e_st[a] = st;
            va_set[a] = 1; va_val[a] = addr;
            if (fl[a]) begin t = a + 1; continue; end
            k = g + 2;
            if (k >= n) break;
            if (hit[k]) begin
                if (fl[k]) t = k + 1;
                else begin mark_done(k + 1, pi, 0); t = k + 2; end
                continue;
            end
            if (k + 1 < n) begin
                if (pi) inc_i[k + 1] = 1;
                else inc_d[k + 1] = 1;
            end
            w = k + 1; flc = fl[k]; flw = 0;
            seen = 0; e = 0; fin = -1; fe = 0; c = w;
            if (!flc)
                for (c = w; c < n; c++) begin
                    if (fl[c]) begin flw = 1; break; end
                    e = e | perr[c] | pexc[c];
                    if (seen && !act[c]) begin
                        fin = c; fe = e; break;
                    end
                    if (!act[c] && c == w + 2) begin
                        fin = c; fe = 1; break;
                    end
                    if (act[c]) seen = 1;
                end
            if (fin >= 0) begin
                mark_done(fin + 1, pi, fe);
                t = fin + 2;
            end else if (flc || flw) begin
                fw = flc ? k + 1 : c + 1;
                f = -1;
                for (int j = fw; j < n; j++)
                    if (!act[j]) begin f = j; break; end
                if (f < 0) break;
                t = f + 1;
            end else begin
                break;
            end
        end
        is = 0; ds = 0; ic = 0; dc = 0; cur = '0;
        for (int j = 0; j < L; j++) begin
            e_imiss[j] = (j >= ia) && (is < ni);
            e_dmiss[j] = (j >= da) && (ds < nd);
            e_iaddr[j] = ibase + 32'(is) * 32'h1000;
            e_daddr[j] = dbase + 32'(ds) * 32'h1000;
            if (e_igr[j]) is++;
            if (e_dgr[j]) ds++;
            ic += int'(inc_i[j]);
            dc += int'(inc_d[j]);
            e_icnt[j] = ic; e_dcnt[j] = dc;
            if (va_set[j]) cur = va_val[j];
            e_va[j] = cur;
        end
    endfunction

    int cyc = 0;
    bit cmp_on = 0;
    bit rst_chk = 0;

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    always @(negedge clk) begin
        if (rst_chk) begin
            chk("reset_flags", -1,
                32'({itlb_grant, dtlb_grant, access, itlb_req,
                     lsu_store, itlb_done, dtlb_done, error}), 0);
            chk("reset_vaddr", -1, svaddr, 0);
            chk("reset_itlb_walks", -1, 32'(iwalks), 0);
            chk("reset_dtlb_walks", -1, 32'(dwalks), 0);
        end else if (cmp_on) begin
            chk("flags", cyc,
                32'({itlb_grant, dtlb_grant, access, itlb_req,
                     lsu_store, itlb_done, dtlb_done, error}),
                32'({e_igr[cyc], e_dgr[cyc], e_acc[cyc],
                     e_ireq[cyc], e_st[cyc], e_idone[cyc],
                     e_ddone[cyc], e_err[cyc]}));
            chk("vaddr", cyc, svaddr, e_va[cyc]);
            chk("itlb_walks", cyc, 32'(iwalks),
                32'(sat(e_icnt[cyc], 65535)));
            chk("dtlb_walks", cyc, 32'(dwalks),
                32'(sat(e_dcnt[cyc], 65535)));
            chk("sat_flags", cyc,
                32'({s_igr, s_dgr, s_acc, s_ireq,
                     s_st, s_idone, s_ddone, s_err}),
                32'({e_igr[cyc], e_dgr[cyc], e_acc[cyc],
                     e_ireq[cyc], e_st[cyc], e_idone[cyc],
                     e_ddone[cyc], e_err[cyc]}));
            chk("sat_vaddr", cyc, s_va, e_va[cyc]);
            chk("sat_walks", cyc, 32'({s_iw, s_dw}),
                32'({3'(sat(e_icnt[cyc], 7)),
                     3'(sat(e_dcnt[cyc], 7))}));
        end
    end

    task automatic drive_idle();
        flush_i = 0; itlb_miss_i = 0; itlb_vaddr_i = '0;
        dtlb_miss_i = 0; dtlb_vaddr_i = '0; dtlb_is_store_i = 0;
        shared_tlb_hit_i = 0; ptw_active_i = 0;
        ptw_error_i = 0; ptw_access_exception_i = 0;
    endtask

    task automatic run();
        build();
        cmp_on = 0;
        rst_ni = 0;
        drive_idle();
        @(posedge clk); #1;
        rst_chk = 1;
        @(posedge clk); #1;
        rst_chk = 0;
        rst_ni = 1;
        for (int c = 0; c < n; c++) begin
            cyc = c;
            itlb_miss_i = e_imiss[c];
            itlb_vaddr_i = e_iaddr[c];
            dtlb_miss_i = e_dmiss[c];
            dtlb_vaddr_i = e_daddr[c];
            dtlb_is_store_i = dstore;
            shared_tlb_hit_i = hit[c];
            ptw_active_i = act[c];
            ptw_error_i = perr[c];
            ptw_access_exception_i = pexc[c];
            flush_i = fl[c];
            cmp_on = 1;
            @(posedge clk); #1;
        end
        cmp_on = 0;
    endtask

    initial begin
        int first, dones;
        rst_ni = 0;
        drive_idle();

        // DTLB store walk cut short by reset on the next scenario
        clear_scn();
        da = 0; nd = 1; dstore = 1; dbase = 32'h4000_0000;
        for (int c = 3; c <= 6; c++) act[c] = 1;
        n = 5;
        run();

        // ITLB hit
        clear_scn();
        ia = 0; ni = 1; ibase = 32'h8000_1000; n = 6;
        for (int c = 0; c < L; c++) hit[c] = 1;
        run();
        chk("pin_s1_grant", 0, 32'(e_igr[0]), 1);
        chk("pin_s1_va", 1, e_va[1], 32'h8000_1000);
        chk("pin_s1_done", 3, 32'({e_idone[3], e_err[3]}), 2);
        chk("pin_s1_cnt", 5, 32'(e_icnt[5]), 0);

        // both miss after reset, DTLB wins
        clear_scn();
        ia = 0; ni = 1; ibase = 32'h0001_0000;
        da = 0; nd = 1; dbase = 32'h0002_0000; n = 10;
        for (int c = 0; c < L; c++) hit[c] = 1;
        run();
        chk("pin_s2_dgr", 0, 32'({e_dgr[0], e_igr[0]}), 2);
        chk("pin_s2_ddone", 3, 32'(e_ddone[3]), 1);
        chk("pin_s2_igr", 4, 32'(e_igr[4]), 1);
        chk("pin_s2_idone", 7, 32'(e_idone[7]), 1);

        // DTLB store walk with page fault
        clear_scn();
        da = 0; nd = 1; dstore = 1; dbase = 32'h4000_2000; n = 10;
        for (int c = 3; c <= 6; c++) act[c] = 1;
        perr[5] = 1;
        run();
        chk("pin_s3_store", 1, 32'(e_st[1]), 1);
        chk("pin_s3_cnt", 4, 32'(e_dcnt[4]), 1);
        chk("pin_s3_done", 8, 32'({e_ddone[8], e_err[8]}), 3);

        // flush mid-walk with ITLB pending
        clear_scn();
        da = 0; nd = 1; dbase = 32'h5000_0000;
        ia = 2; ni = 1; ibase = 32'h6000_0000; n = 13;
        for (int c = 3; c <= 6; c++) act[c] = 1;
        fl[4] = 1; hit[10] = 1;
        run();
        first = -1; dones = 0;
        for (int c = 0; c < n; c++) begin
            if (first < 0 && e_igr[c]) first = c;
            if (c < 11) dones += int'(e_ddone[c]) + int'(e_idone[c]);
        end
        chk("pin_s4_first_igr", 0, 32'(first), 8);
        chk("pin_s4_no_done", 0, 32'(dones), 0);
        chk("pin_s4_idone", 11, 32'(e_idone[11]), 1);

        // walk timeout
        clear_scn();
        ia = 0; ni = 1; ibase = 32'h7000_0000; n = 9;
        run();
        chk("pin_s5_done", 6, 32'({e_idone[6], e_err[6]}), 3);
        chk("pin_s5_cnt", 3, 32'(e_icnt[3]), 1);

        // access fault on the falling cycle
        clear_scn();
        da = 0; nd = 1; dbase = 32'h1234_5000; n = 9;
        act[3] = 1; act[4] = 1; pexc[5] = 1;
        run();
        chk("pin_s6_done", 6, 32'({e_ddone[6], e_err[6]}), 3);

        // flush coincident with grant request
        clear_scn();
        ia = 0; ni = 1; ibase = 32'h2000_0000; n = 7;
        for (int c = 0; c < L; c++) hit[c] = 1;
        fl[0] = 1;
        run();
        chk("pin_s7_grant", 1, 32'({e_igr[0], e_igr[1]}), 1);
        chk("pin_s7_done", 4, 32'(e_idone[4]), 1);

        // flush during RESP keeps the pulse
        clear_scn();
        ia = 0; ni = 1; ibase = 32'h2100_0000; n = 6;
        for (int c = 0; c < L; c++) hit[c] = 1;
        fl[3] = 1;
        run();
        chk("pin_s8_done", 3, 32'(e_idone[3]), 1);

        // flush during LOOKUP aborts silently
        clear_scn();
        ia = 0; ni = 1; ibase = 32'h2200_0000; n = 6;
        for (int c = 0; c < L; c++) hit[c] = 1;
        fl[1] = 1;
        run();

        // flush on CHECK miss waits for the PTW
        clear_scn();
        da = 0; nd = 1; dbase = 32'h3000_0000;
        ia = 4; ni = 1; ibase = 32'h3100_0000; n = 11;
        act[3] = 1; act[4] = 1; fl[2] = 1; hit[8] = 1;
        run();
        chk("pin_s10_igr", 6, 32'(e_igr[6]), 1);
        chk("pin_s10_cnt", 10, 32'(e_dcnt[10]), 1);

        // round robin after a lone ITLB grant
        clear_scn();
        ia = 0; ni = 2; ibase = 32'h0A00_0000;
        da = 1; nd = 1; dbase = 32'h0B00_0000; n = 13;
        for (int c = 0; c < L; c++) hit[c] = 1;
        run();
        chk("pin_s11_dgr", 4, 32'(e_dgr[4]), 1);
        chk("pin_s11_igr", 8, 32'(e_igr[8]), 1);

        // back-to-back timeout walks drive counters into saturation
        clear_scn();
        ia = 0; ni = 10; ibase = 32'h1000_0000; n = 72;
        run();
        chk("pin_s12_cnt", 71, 32'(e_icnt[71]), 10);
        chk("pin_s12_last_done", 69, 32'(e_idone[69]), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
